conv_enc: RTL and testbench

Rate-1/2, constraint-length-4 convolutional encoder that produces the 2-bit code symbols consumed by the Viterbi decoder's branch-metric stage. It accepts one information bit per handshake and emits one registered symbol per handshake. At each frame end it zero-terminates the trellis so the decoder's traceback always starts from state 000. The block sits at the transmit side of the Viterbi test path, between the bit source and the channel model.

---
 rtl/conv_enc_pkg.sv | 23 ++
 rtl/conv_enc_if.sv | 30 +++
 rtl/conv_enc_parity.sv | 16 +
 rtl/conv_enc.sv | 162 ++++++++++++++++
 tb/tb_conv_enc.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/conv_enc_pkg.sv
// viterbi_pkg: types and defaults shared by the Viterbi test-path blocks.
// Contents:
//   K_DEF, NSTATE      - constraint length and matching decoder state count
//   G0_DEF, G1_DEF     - default generators (bit K-1 taps the input bit)
//   enc_state_t        - encoder frame state
//   sym_t              - 2-bit code symbol {parity(G0&w), parity(G1&w)}
package viterbi_pkg;

    localparam int unsigned K_DEF  = 4;
    localparam int unsigned NSTATE = 8;

    localparam logic [K_DEF-1:0] G0_DEF = 4'b1111;
    localparam logic [K_DEF-1:0] G1_DEF = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    typedef logic [1:0] sym_t;

endpackage

// File: rtl/conv_enc_if.sv
// conv_enc_if: bit-in / symbol-out handshake bundle for conv_enc.
// Signals:
//   in_valid, in_bit, in_last - information bit stream (source -> encoder)
//   in_ready                  - encoder accepts the bit this cycle
//   out_ready                 - downstream accepts the symbol this cycle
//   sym_valid, sym, sym_last  - registered code symbol (encoder -> sink)
// Modports: master = bit source / symbol sink side, slave = encoder side.
interface conv_enc_if;
    import viterbi_pkg::*;

    logic in_valid;
    logic in_bit;
    logic in_last;
    logic in_ready;
    logic out_ready;
    logic sym_valid;
    sym_t sym;
    logic sym_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, sym_valid, sym, sym_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, sym_valid, sym, sym_last
    );

endinterface

// File: rtl/conv_enc_parity.sv
// conv_parity: one generator output of the convolutional encoder.
// Ports:
//   w_i - encode window {current bit, shift register}
//   g_i - generator polynomial taps
//   p_o - parity of the tapped window bits
module conv_parity #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] w_i,
    input  logic [W-1:0] g_i,
    output logic         p_o
);

    assign p_o = ^(w_i & g_i);

endmodule

// File: rtl/conv_enc.sv
// conv_enc: rate-1/2 convolutional encoder feeding the Viterbi decoder.
// One information bit in per handshake, one registered 2-bit symbol out.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   enable - low aborts the current frame on the next edge and holds idle
//   enc    - conv_enc_if.slave: bit input and symbol output handshakes
// Build option CONV_ENC_TAIL_EN: append K-1 zero tail bits after each frame
// so the trellis ends in state 0; sym_last marks the last tail symbol.
// Without it, sym_last marks the in_last data symbol and sr clears after it.
module conv_enc
    import viterbi_pkg::*;
#(
    parameter int unsigned  K  = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    conv_enc_if.slave enc
);

    enc_state_t   state_q, state_d;
    logic [K-2:0] sr_q, sr_d;
    logic         sym_valid_q, sym_valid_d;
    logic         sym_last_q, sym_last_d;
    sym_t         sym_q, sym_d;

    logic         upd;
    logic         in_ready;
    logic         accept;
    logic         load;
    logic         last_sym;
    logic         b;
    logic [K-1:0] w;
    logic         p0, p1;

`ifdef CONV_ENC_TAIL_EN
    localparam logic [1:0] TCNT_LAST = 2'(K - 2);
    logic [1:0] tcnt_q, tcnt_d;
    logic       tail_step;
`endif

    // The output register may take a new symbol when empty or being drained.
    assign upd    = !sym_valid_q || enc.out_ready;
    assign accept = enc.in_valid && in_ready;

`ifdef CONV_ENC_TAIL_EN
    assign in_ready  = rst && enable && (state_q != TAIL) && upd;
    assign tail_step = enable && (state_q == TAIL) && upd;
    assign load      = accept || tail_step;
    assign last_sym  = tail_step && (tcnt_q == TCNT_LAST);
`else
    assign in_ready  = rst && enable && upd;
    assign load      = accept;
    assign last_sym  = accept && enc.in_last;
`endif

    // Tail bits are zero: b is the data bit only when one is accepted.
    assign b = accept ? enc.in_bit : 1'b0;
    assign w = {b, sr_q};

    conv_parity #(.W(K)) u_par0 (.w_i(w), .g_i(G0), .p_o(p0));
    conv_parity #(.W(K)) u_par1 (.w_i(w), .g_i(G1), .p_o(p1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            sym_valid_q <= 1'b0;
            sym_q       <= '0;
            sym_last_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            sym_valid_q <= sym_valid_d;
            sym_q       <= sym_d;
            sym_last_q  <= sym_last_d;
`ifdef CONV_ENC_TAIL_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
`ifdef CONV_ENC_TAIL_EN
        tcnt_d  = tcnt_q;
`endif
        if (!enable) begin
            state_d = IDLE;
            sr_d    = '0;
`ifdef CONV_ENC_TAIL_EN
            tcnt_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE, DATA: begin
                    if (accept) begin
                        sr_d    = {b, sr_q[K-2:1]};
                        state_d = DATA;
                        if (enc.in_last) begin
`ifdef CONV_ENC_TAIL_EN
                            state_d = TAIL;
                            tcnt_d  = '0;
`else
                            state_d = IDLE;
                            sr_d    = '0;
`endif
                        end
                    end
                end
`ifdef CONV_ENC_TAIL_EN
                TAIL: begin
                    if (tail_step) begin
                        // After K-1 zero shifts sr is 0 without an explicit clear.
                        sr_d   = {1'b0, sr_q[K-2:1]};
                        tcnt_d = tcnt_q + 2'd1;
                        if (tcnt_q == TCNT_LAST) begin
                            state_d = IDLE;
                            tcnt_d  = '0;
                        end
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    sr_d    = '0;
                end
            endcase
        end
    end

    // Output logic: next value of the symbol register
    always_comb begin
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        if (!enable) begin
            sym_valid_d = 1'b0;
        end else if (load) begin
            sym_d       = {p0, p1};
            sym_valid_d = 1'b1;
            sym_last_d  = last_sym;
        end else if (enc.out_ready) begin
            sym_valid_d = 1'b0;
        end
    end

    assign enc.in_ready  = in_ready;
    assign enc.sym_valid = sym_valid_q;
    assign enc.sym       = sym_q;
    assign enc.sym_last  = sym_last_q;

endmodule

// File: tb/tb_conv_enc.sv
// tb_conv_enc: directed self-checking bench for conv_enc.
// Expected symbols are hand-derived with G0=1111, G1=1011, w={b,sr},
// sr <= {b, sr[2:1]}. Both the CONV_ENC_TAIL_EN build and the default
// build are covered; the expected tables follow the macro.
module tb_conv_enc;
    import viterbi_pkg::*;

    logic clk;
    logic rst;
    logic enable;
    int   passes = 0;
    int   total  = 0;

    conv_enc_if bus ();

    conv_enc dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .enc    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drives one stream of bits (MSB-first packed) and checks the symbol
    // stream (MSB-first, 2 bits each) plus sym_last flags as they drain.
    task automatic run(input string tag, input int nb, input logic [15:0] bits,
                       input logic [15:0] lasts, input int ns,
                       input logic [31:0] syms, input logic [15:0] slast,
                       input bit stall);
        int   idx = 0;
        int   got = 0;
        int   cyc = 0;
        int   tail_left = 0;
        bit   prev_stall = 1'b0;
        sym_t prev_sym = '0;
        logic prev_last = 1'b0;
        while (got < ns && cyc < 100) begin
            @(negedge clk);
            bus.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (idx < nb) begin
                bus.in_valid = 1'b1;
                bus.in_bit   = bits[nb-1-idx];
                bus.in_last  = lasts[nb-1-idx];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_bit   = 1'b0;
                bus.in_last  = 1'b0;
            end
            #1;
            if (prev_stall)
                chk({tag, " hold"}, {5'd0, bus.sym_valid, bus.sym_last, bus.sym[1]} ^ {7'd0, 1'b0},
                    {5'd0, 1'b1, prev_last, prev_sym[1]});
            if (prev_stall)
                chk({tag, " hold_lsb"}, {7'd0, bus.sym[0]}, {7'd0, prev_sym[0]});
            if (bus.sym_valid && !bus.out_ready)
                chk({tag, " stall_ready"}, {7'd0, bus.in_ready}, 8'd0);
            if (tail_left > 0) begin
                chk({tag, " tail_ready"}, {7'd0, bus.in_ready}, 8'd0);
                tail_left--;
            end
            prev_stall = bus.sym_valid && !bus.out_ready;
            prev_sym   = bus.sym;
            prev_last  = bus.sym_last;
            if (bus.sym_valid && bus.out_ready) begin
                chk($sformatf("%s sym%0d", tag, got), {5'd0, bus.sym_last, bus.sym},
                    {5'd0, slast[ns-1-got], syms[2*(ns-1-got) +: 2]});
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
`ifdef CONV_ENC_TAIL_EN
                if (bus.in_last) tail_left = 3;
`endif
                idx++;
            end
            cyc++;
        end
        chk({tag, " nsym"}, 8'(got), 8'(ns));
        chk({tag, " nbits"}, 8'(idx), 8'(nb));
        if (!stall) chk({tag, " cycles"}, 8'(cyc), 8'(ns + 1));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, " idle"}, {6'd0, bus.sym_valid, bus.in_ready}, 8'b0000_0001);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset", {4'd0, bus.sym_valid, bus.sym, bus.sym_last}, 8'd0);
        chk("reset_ready", {7'd0, bus.in_ready}, 8'd0);
        rst = 1'b1;
        @(negedge clk);

`ifdef CONV_ENC_TAIL_EN
        run("f1011", 4, 16'b1011, 16'b0001, 7, 32'b11_10_00_10_01_00_11, 16'b0000001, 1'b0);
        run("f1011_stall", 4, 16'b1011, 16'b0001, 7, 32'b11_10_00_10_01_00_11, 16'b0000001, 1'b1);
        run("single", 1, 16'b1, 16'b1, 4, 32'b11_10_11_11, 16'b0001, 1'b0);
        run("b2b_zero", 4, 16'b0000, 16'b0101, 10, 32'd0, 16'b00001_00001, 1'b0);
`else
        run("f1011", 4, 16'b1011, 16'b0001, 4, 32'b11_10_00_10, 16'b0001, 1'b0);
        run("f1011_stall", 4, 16'b1011, 16'b0001, 4, 32'b11_10_00_10, 16'b0001, 1'b1);
        run("single", 1, 16'b1, 16'b1, 1, 32'b11, 16'b1, 1'b0);
        run("b2b_zero", 4, 16'b0000, 16'b0101, 4, 32'd0, 16'b0101, 1'b0);
`endif

        // Abort with a pending symbol: it is dropped and sr is cleared.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        bus.in_last   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("abort_pending", {5'd0, bus.sym_valid, bus.sym}, 8'b0000_0111);
        enable = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_drop", {7'd0, bus.sym_valid}, 8'd0);
        enable        = 1'b1;
        bus.out_ready = 1'b1;

`ifdef CONV_ENC_TAIL_EN
        // Abort during the second tail symbol.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        bus.in_last  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1 chk("tab_d", {5'd0, bus.sym_valid, bus.sym}, 8'b0000_0111);
        @(negedge clk);
        #1 chk("tab_t1", {5'd0, bus.sym_valid, bus.sym}, 8'b0000_0110);
        @(negedge clk);
        #1 chk("tab_t2", {5'd0, bus.sym_valid, bus.sym}, 8'b0000_0111);
        enable = 1'b0;
        @(negedge clk);
        #1 chk("tab_drop", {7'd0, bus.sym_valid}, 8'd0);
        enable = 1'b1;
        run("after_abort", 1, 16'b1, 16'b1, 4, 32'b11_10_11_11, 16'b0001, 1'b0);
`else
        run("after_abort", 1, 16'b1, 16'b1, 1, 32'b11, 16'b1, 1'b0);
`endif

        // Asynchronous reset mid-DATA.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        bus.in_last  = 1'b0;
        @(negedge clk);
        bus.in_bit = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("mid_data", {5'd0, bus.sym_valid, bus.sym}, 8'b0000_0110);
        rst = 1'b0;
        #1 chk("async_rst", {3'd0, bus.sym_valid, bus.sym, bus.sym_last, bus.in_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
`ifdef CONV_ENC_TAIL_EN
        run("after_rst", 2, 16'b10, 16'b01, 5, 32'b11_10_11_11_00, 16'b00001, 1'b0);
`else
        run("after_rst", 2, 16'b10, 16'b01, 2, 32'b11_10, 16'b01, 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
